// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer types used by rename, the execution units and the ROB.
//   ROB_DEPTH  default number of ROB entries (power of two, >= 2)
//   PREG_W     physical register index width
//   AREG_W     architectural register index width
//   rob_tag_t  ROB entry index
//   rob_entry_t  per-entry state: valid, done, rd, prd_new, prd_old
package reorder_buffer_pkg;

  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned PREG_W    = 6;
  localparam int unsigned AREG_W    = 5;
  localparam int unsigned ROB_TAG_W = $clog2(ROB_DEPTH);

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [AREG_W-1:0] rd;
    logic [PREG_W-1:0] prd_new;
    logic [PREG_W-1:0] prd_old;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement queue behind rename.
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   alloc_valid/rd/prd_new/prd_old  one renamed instruction per cycle
//   alloc_tag                     entry index given to the allocating instruction (tail)
//   stall_out                     buffer full, back-pressures rename
//   complete_valid/complete_tag   execution completion for an entry
//   flush                         discard all entries
//   retire_valid/rd/prd           oldest completed entry retiring this cycle
//   commit_free/prd_free          superseded physical register returned to free list
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = ROB_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_valid,
  input  logic [AREG_W-1:0]          alloc_rd,
  input  logic [PREG_W-1:0]          alloc_prd_new,
  input  logic [PREG_W-1:0]          alloc_prd_old,
  output logic [$clog2(DEPTH)-1:0]   alloc_tag,
  output logic                       stall_out,
  input  logic                       complete_valid,
  input  logic [$clog2(DEPTH)-1:0]   complete_tag,
  input  logic                       flush,
  output logic                       commit_free,
  output logic [PREG_W-1:0]          prd_free,
  output logic                       retire_valid,
  output logic [AREG_W-1:0]          retire_rd,
  output logic [PREG_W-1:0]          retire_prd
);

  localparam int unsigned TAG_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = TAG_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  rob_entry_t       r_mem [DEPTH];
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  rob_entry_t w_head_entry;
  logic       w_full;
  logic       w_alloc;
  logic       w_retire;

  always_comb begin
    w_head_entry = r_mem[r_head];
    w_full       = (r_count == FULL_CNT);
    // Full is judged on registered count only: a same-cycle retire does not
    // open a slot for a same-cycle alloc.
    w_alloc      = alloc_valid && !w_full;
    w_retire     = w_head_entry.valid && w_head_entry.done && !flush;
  end

  assign alloc_tag    = r_tail;
  assign stall_out    = w_full;
  assign retire_valid = w_retire;
  assign retire_rd    = w_head_entry.rd;
  assign retire_prd   = w_head_entry.prd_new;
  assign prd_free     = w_head_entry.prd_old;
  assign commit_free  = w_retire && (w_head_entry.rd != '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_mem   <= '{default: '0};
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_retire) begin
        r_mem[r_head].valid <= 1'b0;
        r_head              <= r_head + TAG_W'(1);
      end
      // Alloc never targets the head slot while that slot is valid (it would
      // require a full buffer), so it cannot collide with the retire write.
      if (w_alloc) begin
        r_mem[r_tail] <= '{valid: 1'b1, done: 1'b0, rd: alloc_rd,
                           prd_new: alloc_prd_new, prd_old: alloc_prd_old};
        r_tail        <= r_tail + TAG_W'(1);
      end
      if (complete_valid && r_mem[complete_tag].valid) begin
        r_mem[complete_tag].done <= 1'b1;
      end
      case ({w_alloc, w_retire})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
